// File: rtl/gun_pkg.sv
// rtl/gun_pkg.sv - shared axis state type, position defaults and clamped step helper
// Build option: GUN_ACCEL_EN adds the FAST axis state.
package gun_pkg;

  localparam int POS_W        = 6;
  localparam int DEF_POS_MAX  = 62;
  localparam int DEF_POS_INIT = 31;

`ifdef GUN_ACCEL_EN
  typedef enum logic [1:0] {IDLE, SLOW, FAST} axis_state_t;
`else
  typedef enum logic {IDLE, SLOW} axis_state_t;
`endif

  // One step of size 1 or 2, computed one bit wider so both ends clamp instead of wrapping
  function automatic logic [POS_W-1:0] clamp_step(
    input logic [POS_W-1:0] pos,
    input logic             up,
    input logic [1:0]       step,
    input logic [POS_W-1:0] max_pos
  );
    logic [POS_W:0] sum;
    if (up) begin
      sum = {1'b0, pos} + {{(POS_W-1){1'b0}}, step};
      if (sum > {1'b0, max_pos}) sum = {1'b0, max_pos};
    end else begin
      sum = {1'b0, pos} - {{(POS_W-1){1'b0}}, step};
      if (sum[POS_W]) sum = '0;
    end
    return sum[POS_W-1:0];
  endfunction

endpackage

// File: rtl/gun_axis.sv
// rtl/gun_axis.sv - one gun axis: tick-paced stepping, reversal handling and clamped position
// Build option: GUN_ACCEL_EN enables the hold counter and the FAST state.
module gun_axis
  import gun_pkg::*;
#(
  parameter int POS_MAX    = DEF_POS_MAX,
  parameter int POS_INIT   = DEF_POS_INIT,
  parameter int DIV_TICKS  = 3,
  parameter int ACCEL_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_p,
  input  logic             center,
  input  logic             dec,
  input  logic             inc,
  output logic [POS_W-1:0] pos,
  output axis_state_t      state_next
);

  localparam int DIV_W = (DIV_TICKS > 1) ? $clog2(DIV_TICKS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV_TICKS - 1);
  localparam logic [DIV_W-1:0] DIV_ENTRY = (DIV_TICKS > 1) ? DIV_W'(1) : '0;
  localparam logic [POS_W-1:0] MAX_P     = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] INIT_P    = POS_W'(POS_INIT);

  if (DIV_TICKS < 1 || ACCEL_HOLD < 1 || POS_INIT > POS_MAX) begin : g_bad_cfg
    $error("gun_axis: illegal parameter combination");
  end

  axis_state_t      state;
  logic [DIV_W-1:0] div, div_n;
  logic             last_inc, last_inc_n;
  logic [POS_W-1:0] pos_n;
  logic             dir_valid;

  assign dir_valid = dec ^ inc;

`ifdef GUN_ACCEL_EN
  localparam int HOLD_W = $clog2(ACCEL_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_TOP = HOLD_W'(ACCEL_HOLD);
  logic [HOLD_W-1:0] hold, hold_n;
`endif

  always_comb begin
    state_next = state;
    pos_n      = pos;
    div_n      = div;
    last_inc_n = last_inc;
`ifdef GUN_ACCEL_EN
    hold_n     = hold;
`endif
    if (center) begin
      state_next = IDLE;
      pos_n      = INIT_P;
      div_n      = '0;
      last_inc_n = 1'b0;
`ifdef GUN_ACCEL_EN
      hold_n     = '0;
`endif
    end else if (tick_p) begin
      if (!dir_valid) begin
        state_next = IDLE;
        div_n      = '0;
`ifdef GUN_ACCEL_EN
        hold_n     = '0;
`endif
      end else if (state == IDLE || inc != last_inc) begin
        // Fresh press or reversal: step at once and restart pacing
        state_next = SLOW;
        pos_n      = clamp_step(pos, inc, 2'd1, MAX_P);
        div_n      = DIV_ENTRY;
        last_inc_n = inc;
`ifdef GUN_ACCEL_EN
        hold_n     = HOLD_W'(1);
        if (hold_n == HOLD_TOP) state_next = FAST;
`endif
      end else begin
        div_n = (div == DIV_LAST) ? '0 : div + 1'b1;
        if (div == '0) begin
`ifdef GUN_ACCEL_EN
          pos_n = clamp_step(pos, inc, (state == FAST) ? 2'd2 : 2'd1, MAX_P);
          if (state == SLOW) begin
            if (hold != HOLD_TOP) hold_n = hold + 1'b1;
            if (hold_n == HOLD_TOP) state_next = FAST;
          end
`else
          pos_n = clamp_step(pos, inc, 2'd1, MAX_P);
`endif
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pos      <= INIT_P;
      div      <= '0;
      last_inc <= 1'b0;
`ifdef GUN_ACCEL_EN
      hold     <= '0;
`endif
    end else begin
      state    <= state_next;
      pos      <= pos_n;
      div      <= div_n;
      last_inc <= last_inc_n;
`ifdef GUN_ACCEL_EN
      hold     <= hold_n;
`endif
    end
  end

endmodule

// File: rtl/gun_position_ctrl.sv
// rtl/gun_position_ctrl.sv - joystick to 6-bit light-gun coordinates, paced by the 4 ms tick
// Build option: GUN_ACCEL_EN enables hold-to-accelerate on each axis.
module gun_position_ctrl
  import gun_pkg::*;
#(
  parameter int POS_MAX    = DEF_POS_MAX,
  parameter int POS_INIT   = DEF_POS_INIT,
  parameter int DIV_TICKS  = 3,
  parameter int ACCEL_HOLD = 16
) (
  input  logic             clock_12,
  input  logic             reset,
  input  logic             tick_4ms,
  input  logic             joy_left,
  input  logic             joy_right,
  input  logic             joy_up,
  input  logic             joy_down,
  input  logic             center,
  output logic [POS_W-1:0] gun_h,
  output logic [POS_W-1:0] gun_v,
  output logic             moving
);

  logic        tick_d;
  logic        tick_p;
  axis_state_t h_next, v_next;

  assign tick_p = tick_4ms & ~tick_d;

  always_ff @(posedge clock_12 or posedge reset) begin
    if (reset) begin
      tick_d <= 1'b0;
      moving <= 1'b0;
    end else begin
      tick_d <= tick_4ms;
      moving <= (h_next != IDLE) || (v_next != IDLE);
    end
  end

  gun_axis #(
    .POS_MAX   (POS_MAX),
    .POS_INIT  (POS_INIT),
    .DIV_TICKS (DIV_TICKS),
    .ACCEL_HOLD(ACCEL_HOLD)
  ) u_axis_h (
    .clk       (clock_12),
    .rst       (reset),
    .tick_p    (tick_p),
    .center    (center),
    .dec       (joy_left),
    .inc       (joy_right),
    .pos       (gun_h),
    .state_next(h_next)
  );

  gun_axis #(
    .POS_MAX   (POS_MAX),
    .POS_INIT  (POS_INIT),
    .DIV_TICKS (DIV_TICKS),
    .ACCEL_HOLD(ACCEL_HOLD)
  ) u_axis_v (
    .clk       (clock_12),
    .rst       (reset),
    .tick_p    (tick_p),
    .center    (center),
    .dec       (joy_up),
    .inc       (joy_down),
    .pos       (gun_v),
    .state_next(v_next)
  );

endmodule
